// File: rtl/pci_pixel_packer.sv
// Frame-aware PCI ingress adapter: forwards the header bytes of each frame on a side port,
// then packs pixel bytes LANES at a time into wide words and flags the final word of the frame.
module pci_pixel_packer #(
   parameter int DATA_W       = 8,
   parameter int LANES        = 4,
   parameter int HEADER_BYTES = 1078,
   parameter int IMAGE_PIXELS = 262144
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    i_valid_pci,
   input  logic [DATA_W-1:0]       i_data_pci,
   output logic                    o_ready_pci,
   output logic                    o_hdr_valid,
   output logic [DATA_W-1:0]       o_hdr_data,
   output logic                    o_valid,
   output logic [LANES*DATA_W-1:0] o_data,
   output logic                    o_last,
   input  logic                    i_ready,
   output logic                    o_frame_done
);

   if (LANES < 1 || IMAGE_PIXELS % LANES != 0) begin : g_bad_cfg
      $fatal(1, "pci_pixel_packer: IMAGE_PIXELS must be a non-zero multiple of LANES");
   end

   localparam int HW = (HEADER_BYTES > 0) ? $clog2(HEADER_BYTES + 1) : 1;
   localparam int PW = (IMAGE_PIXELS > 1) ? $clog2(IMAGE_PIXELS + 1) : 1;
   localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;

   localparam logic [HW-1:0] HDR_LAST  = HW'(HEADER_BYTES - 1);
   localparam logic [PW-1:0] PIX_LAST  = PW'(IMAGE_PIXELS - 1);
   localparam logic [LW-1:0] LANE_LAST = LW'(LANES - 1);

   typedef enum logic [1:0] {S_HDR, S_PIX, S_DRAIN} state_t;
   localparam state_t S_START = (HEADER_BYTES > 0) ? S_HDR : S_PIX;

   state_t                        state_q, state_d;
   logic [HW-1:0]                 hdr_cnt_q, hdr_cnt_d;
   logic [LW-1:0]                 lane_cnt_q, lane_cnt_d;
   logic [PW-1:0]                 pix_cnt_q, pix_cnt_d;
   logic [LANES-1:0][DATA_W-1:0]  pack_q, pack_d;
   logic [LANES-1:0][DATA_W-1:0]  data_q, data_d;
   logic                          valid_q, valid_d;
   logic                          last_q, last_d;
   logic                          hdr_valid_q, hdr_valid_d;
   logic [DATA_W-1:0]             hdr_data_q, hdr_data_d;
   logic                          done_q, done_d;
   logic                          ready_c;
   logic                          accept_c;
   logic [LANES-1:0][DATA_W-1:0]  word_c;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_START;
         hdr_cnt_q   <= '0;
         lane_cnt_q  <= '0;
         pix_cnt_q   <= '0;
         pack_q      <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         last_q      <= 1'b0;
         hdr_valid_q <= 1'b0;
         hdr_data_q  <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         hdr_cnt_q   <= hdr_cnt_d;
         lane_cnt_q  <= lane_cnt_d;
         pix_cnt_q   <= pix_cnt_d;
         pack_q      <= pack_d;
         data_q      <= data_d;
         valid_q     <= valid_d;
         last_q      <= last_d;
         hdr_valid_q <= hdr_valid_d;
         hdr_data_q  <= hdr_data_d;
         done_q      <= done_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      hdr_cnt_d   = hdr_cnt_q;
      lane_cnt_d  = lane_cnt_q;
      pix_cnt_d   = pix_cnt_q;
      pack_d      = pack_q;
      data_d      = data_q;
      valid_d     = valid_q;
      last_d      = last_q;
      hdr_valid_d = 1'b0;
      hdr_data_d  = hdr_data_q;
      done_d      = 1'b0;
      ready_c     = 1'b0;
      word_c      = pack_q;
      word_c[lane_cnt_q] = i_data_pci;

      // Only the word-completing byte can be blocked, and only by a held word that is not draining.
      case (state_q)
         S_HDR:   ready_c = 1'b1;
         S_PIX:   ready_c = (lane_cnt_q != LANE_LAST) | ~valid_q | i_ready;
         default: ready_c = 1'b0;
      endcase
      ready_c  = ready_c & ~rst;
      accept_c = i_valid_pci & ready_c;

      if (valid_q && i_ready) valid_d = 1'b0;

      case (state_q)
         S_HDR: begin
            if (accept_c) begin
               hdr_valid_d = 1'b1;
               hdr_data_d  = i_data_pci;
               if (hdr_cnt_q == HDR_LAST) begin
                  hdr_cnt_d = '0;
                  state_d   = S_PIX;
               end else begin
                  hdr_cnt_d = hdr_cnt_q + 1'b1;
               end
            end
         end
         S_PIX: begin
            if (accept_c) begin
               pack_d[lane_cnt_q] = i_data_pci;
               pix_cnt_d          = pix_cnt_q + 1'b1;
               if (lane_cnt_q == LANE_LAST) begin
                  lane_cnt_d = '0;
                  valid_d    = 1'b1;
                  data_d     = word_c;
                  last_d     = (pix_cnt_q == PIX_LAST);
               end else begin
                  lane_cnt_d = lane_cnt_q + 1'b1;
               end
               if (pix_cnt_q == PIX_LAST) state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (valid_q && i_ready && last_q) begin
               done_d     = 1'b1;
               hdr_cnt_d  = '0;
               lane_cnt_d = '0;
               pix_cnt_d  = '0;
               state_d    = S_START;
            end
         end
         default: state_d = S_START;
      endcase
   end

   assign o_ready_pci  = ready_c;
   assign o_hdr_valid  = hdr_valid_q;
   assign o_hdr_data   = hdr_data_q;
   assign o_valid      = valid_q;
   assign o_data       = data_q;
   assign o_last       = last_q;
   assign o_frame_done = done_q;

endmodule
